// File: rtl/permutation_xor_pkg.sv
// -----------------------------------------------------------------------------
// ascon_pack: shared types and constant tables for the ASCON-128 permutation
// datapath.
//   type_state  : 5 x 64-bit state, word [0]=x0 .. [4]=x4
//   ROUND_CONST : round constant per round index (12..15 give 8'h00)
//   SBOX        : 5-bit S-box, index {x0,x1,x2,x3,x4} with x0 as the MSB
//   rotr()      : 64-bit rotate right
// -----------------------------------------------------------------------------
package ascon_pack;

  typedef logic [0:4][63:0] type_state;

  localparam logic [0:15][7:0] ROUND_CONST = {
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:31][4:0] SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/permutation_xor_round.sv
// -----------------------------------------------------------------------------
// permutation_xor_round: one combinational ASCON round, pc -> ps -> pl.
//   state_i [320] : round input state
//   round_i [4]   : round index, selects the round constant
//   state_o [320] : round output state
// -----------------------------------------------------------------------------
module permutation_xor_round
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [3:0]  round_i,
  output type_state   state_o
);

  type_state pc;
  type_state ps;
  logic [4:0] sbox_out;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pc        = state_i;
    pc[2]     = state_i[2] ^ {56'h0, ROUND_CONST[round_i]};
    ps        = '0;
    sbox_out  = '0;
    // Bit-slice j across the five words forms one S-box lookup.
    for (int j = 0; j < 64; j++) begin
      sbox_out = SBOX[{pc[0][j], pc[1][j], pc[2][j], pc[3][j], pc[4][j]}];
      ps[0][j] = sbox_out[4];
      ps[1][j] = sbox_out[3];
      ps[2][j] = sbox_out[2];
      ps[3][j] = sbox_out[1];
      ps[4][j] = sbox_out[0];
    end
  end

  assign state_o[0] = ps[0] ^ rotr(ps[0], 19) ^ rotr(ps[0], 28);
  assign state_o[1] = ps[1] ^ rotr(ps[1], 61) ^ rotr(ps[1], 39);
  assign state_o[2] = ps[2] ^ rotr(ps[2],  1) ^ rotr(ps[2],  6);
  assign state_o[3] = ps[3] ^ rotr(ps[3], 10) ^ rotr(ps[3], 17);
  assign state_o[4] = ps[4] ^ rotr(ps[4],  7) ^ rotr(ps[4], 41);

endmodule

// File: rtl/permutation_xor.sv
// -----------------------------------------------------------------------------
// permutation_xor: ASCON-128 datapath core, one permutation round per clock
// with optional key/data XOR stages before and after the round.
//   clock_i, resetb_i        : rising-edge clock, async active-low reset
//   en_i                     : state register write enable
//   sel_i                    : 0 = state_i feeds the round, 1 = state register
//   state_i, round_i         : external state, round index 0..11
//   data_i, key_i            : 64-bit data block, 128-bit key {K_hi,K_lo}
//   en_xor_data_i            : begin stage x0 ^= data_i
//   en_xor_key_begin_i       : begin stage x1 ^= K_hi, x2 ^= K_lo
//   en_cypher_begin_i        : capture x0 after the begin stage
//   en_xor_key_end_i         : end stage x3 ^= K_hi, x4 ^= K_lo
//   en_xor_lsb_i             : end stage x4 ^= 1 (domain separation)
//   en_tag_end_i             : capture {x3,x4} after the end stage
//   cypher_o, tag_o, state_o : registered ciphertext word, tag, state
// -----------------------------------------------------------------------------
module permutation_xor
  import ascon_pack::*;
(
  input  logic          clock_i,
  input  logic          resetb_i,
  input  logic          en_i,
  input  logic          sel_i,
  input  type_state     state_i,
  input  logic [3:0]    round_i,
  input  logic [63:0]   data_i,
  input  logic [127:0]  key_i,
  input  logic          en_xor_data_i,
  input  logic          en_xor_key_begin_i,
  input  logic          en_cypher_begin_i,
  input  logic          en_xor_key_end_i,
  input  logic          en_xor_lsb_i,
  input  logic          en_tag_end_i,
  output logic [63:0]   cypher_o,
  output logic [127:0]  tag_o,
  output type_state     state_o
);

  type_state     state_q, state_d;
  type_state     begin_s, round_s;
  logic [63:0]   cypher_q;
  logic [127:0]  tag_q;

  always_comb begin
    begin_s = sel_i ? state_q : state_i;
    if (en_xor_data_i)      begin_s[0] = begin_s[0] ^ data_i;
    if (en_xor_key_begin_i) begin
      begin_s[1] = begin_s[1] ^ key_i[127:64];
      begin_s[2] = begin_s[2] ^ key_i[63:0];
    end
  end

  permutation_xor_round u_round (
    .state_i (begin_s),
    .round_i (round_i),
    .state_o (round_s)
  );

  always_comb begin
    state_d = round_s;
    if (en_xor_key_end_i) begin
      state_d[3] = state_d[3] ^ key_i[127:64];
      state_d[4] = state_d[4] ^ key_i[63:0];
    end
    if (en_xor_lsb_i) state_d[4] = state_d[4] ^ 64'h1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  // NOTE: all three registers clear asynchronously; a reset mid-permutation
  // discards the round in flight and the sequencer restarts with sel_i=0.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= '0;
      cypher_q <= '0;
      tag_q    <= '0;
    end else begin
      if (en_i)              state_q  <= state_d;
      // Capture enables are independent of en_i.
      if (en_cypher_begin_i) cypher_q <= begin_s[0];
      if (en_tag_end_i)      tag_q    <= {state_d[3], state_d[4]};
    end
  end

  assign state_o  = state_q;
  assign cypher_o = cypher_q;
  assign tag_o    = tag_q;

endmodule

// File: tb/tb_permutation_xor.sv
module tb_permutation_xor;
  import ascon_pack::type_state;

  logic          clock_i = 1'b0;
  logic          resetb_i;
  logic          en_i, sel_i;
  type_state     state_i;
  logic [3:0]    round_i;
  logic [63:0]   data_i;
  logic [127:0]  key_i;
  logic          en_xor_data_i, en_xor_key_begin_i, en_cypher_begin_i;
  logic          en_xor_key_end_i, en_xor_lsb_i, en_tag_end_i;
  logic [63:0]   cypher_o;
  logic [127:0]  tag_o;
  type_state     state_o;

  permutation_xor dut (
    .clock_i            (clock_i),
    .resetb_i           (resetb_i),
    .en_i               (en_i),
    .sel_i              (sel_i),
    .state_i            (state_i),
    .round_i            (round_i),
    .data_i             (data_i),
    .key_i              (key_i),
    .en_xor_data_i      (en_xor_data_i),
    .en_xor_key_begin_i (en_xor_key_begin_i),
    .en_cypher_begin_i  (en_cypher_begin_i),
    .en_xor_key_end_i   (en_xor_key_end_i),
    .en_xor_lsb_i       (en_xor_lsb_i),
    .en_tag_end_i       (en_tag_end_i),
    .cypher_o           (cypher_o),
    .tag_o              (tag_o),
    .state_o            (state_o)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (bit-sliced S-box form) ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state model_round(input type_state s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    if (r < 4'd12) x2 ^= {56'h0, (4'hf - r), r};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2,  1) ^ ror(x2,  6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4,  7) ^ ror(x4, 41);
    return o;
  endfunction

  typedef struct packed {
    type_state     st;
    logic [63:0]   cy;
    logic [127:0]  tg;
  } exp_t;

  exp_t          exp_q[$];
  type_state     m_state;
  logic [63:0]   m_cy;
  logic [127:0]  m_tg;

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    type_state s_b, s_e;
    exp_t e, got;
    s_b = sel_i ? m_state : state_i;
    if (en_xor_data_i) s_b[0] ^= data_i;
    if (en_xor_key_begin_i) begin
      s_b[1] ^= key_i[127:64];
      s_b[2] ^= key_i[63:0];
    end
    s_e = model_round(s_b, round_i);
    if (en_xor_key_end_i) begin
      s_e[3] ^= key_i[127:64];
      s_e[4] ^= key_i[63:0];
    end
    if (en_xor_lsb_i) s_e[4] ^= 64'h1;
    if (en_i)              m_state = s_e;
    if (en_cypher_begin_i) m_cy    = s_b[0];
    if (en_tag_end_i)      m_tg    = {s_e[3], s_e[4]};
    exp_q.push_back('{st: m_state, cy: m_cy, tg: m_tg});
    @(posedge clock_i);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 320'd1, 320'd0);
    end else begin
      e = exp_q.pop_front();
      got = '{st: state_o, cy: cypher_o, tg: tag_o};
      check({tag, "_state"},  got.st, e.st);
      check({tag, "_cypher"}, {256'h0, got.cy}, {256'h0, e.cy});
      check({tag, "_tag"},    {192'h0, got.tg}, {192'h0, e.tg});
    end
    @(negedge clock_i);
  endtask

  task automatic idle_inputs();
    en_i = 1'b1; sel_i = 1'b0; state_i = '0; round_i = 4'd0;
    data_i = '0; key_i = '0;
    en_xor_data_i = 0; en_xor_key_begin_i = 0; en_cypher_begin_i = 0;
    en_xor_key_end_i = 0; en_xor_lsb_i = 0; en_tag_end_i = 0;
  endtask

  task automatic randomize_inputs();
    state_i = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
    data_i  = {$urandom, $urandom};
    key_i   = {$urandom, $urandom, $urandom, $urandom};
    round_i = 4'($urandom_range(0, 15));
    sel_i = 1'($urandom); en_xor_data_i = 1'($urandom);
    en_xor_key_begin_i = 1'($urandom); en_xor_key_end_i = 1'($urandom);
    en_xor_lsb_i = 1'($urandom);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_state"},  state_o, 320'h0);
    check({tag, "_cypher"}, {256'h0, cypher_o}, 320'h0);
    check({tag, "_tag"},    {192'h0, tag_o}, 320'h0);
    m_state = '0; m_cy = '0; m_tg = '0;
  endtask

  localparam type_state IV = {64'h80400c0600000000, 64'h8a55114d1cb6a9a2,
                              64'hbe263d4d7aecaaff, 64'h4ed0ec0b98c529b7,
                              64'hc8cddf37bcd0284a};
  localparam logic [127:0] KEY = 128'h8a55114d1cb6a9a2be263d4d7aecaaff;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs, before any clock edge.
    resetb_i = 1'b0;
    idle_inputs();
    randomize_inputs();
    en_cypher_begin_i = 1; en_tag_end_i = 1;
    #2;
    check_reset_zero("reset_init");
    @(negedge clock_i);
    resetb_i = 1'b1;
    idle_inputs();

    // p12 on IV state.
    state_i = IV;
    for (int r = 0; r < 12; r++) begin
      sel_i   = (r != 0);
      round_i = 4'(r);
      step($sformatf("p12_r%0d", r));
    end

    // Cypher capture.
    idle_inputs();
    state_i[0] = 64'h80400c0600000000;
    data_i = 64'h3230323380000000;
    en_xor_data_i = 1; en_cypher_begin_i = 1;
    step("cypher");
    check("cypher_const", {256'h0, cypher_o}, {256'h0, 64'hb2703e3580000000});

    // Key-end, lsb and tag capture.
    idle_inputs();
    state_i = IV; key_i = KEY; round_i = 4'd6;
    en_xor_key_end_i = 1; en_xor_lsb_i = 1; en_tag_end_i = 1;
    step("keyend");

    // Hold: en_i and capture enables low while everything else toggles.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      en_i = 0; en_cypher_begin_i = 0; en_tag_end_i = 0;
      step($sformatf("hold%0d", i));
    end

    // Key-begin on zero state, round 0.
    idle_inputs();
    key_i = KEY; en_xor_key_begin_i = 1;
    step("keybegin");
    check("keybegin_direct", state_o,
          model_round({64'h0, KEY[127:64], KEY[63:0], 64'h0, 64'h0}, 4'd0));

    // Random mix, including round indices 12..15.
    for (int i = 0; i < 20; i++) begin
      randomize_inputs();
      en_i = 1'($urandom); en_cypher_begin_i = 1'($urandom);
      en_tag_end_i = 1'($urandom);
      step($sformatf("rand%0d", i));
    end

    // Reset mid-permutation, then restart p6.
    idle_inputs();
    state_i = IV; en_cypher_begin_i = 1; en_tag_end_i = 1;
    for (int r = 0; r < 3; r++) begin
      sel_i = (r != 0); round_i = 4'(r + 6);
      step($sformatf("pre_rst%0d", r));
    end
    resetb_i = 1'b0;
    #1;
    check_reset_zero("reset_mid");
    @(negedge clock_i);
    resetb_i = 1'b1;
    for (int r = 6; r < 12; r++) begin
      sel_i = (r != 6); round_i = 4'(r);
      step($sformatf("p6_r%0d", r));
    end

    check("queue_empty", 320'(exp_q.size()), 320'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
